alu_cmd_sequencer: RTL

Upstream/downstream wrapper for the 4-bit combinational ALU (A[3:0], B[3:0], S[1:0] -> C[7:0]). It buffers operation commands in a small FIFO, drives registered operands and opcode into the ALU, captures the 8-bit result one cycle later, and returns it over a valid/ready result interface. It also flags divide-by-zero, which the ALU itself does not detect.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_cmd_fifo.sv | 73 +++++++
 rtl/alu_cmd_sequencer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, FSM state and error-result definitions for the ALU command
// sequencer and its FIFO.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [7:0] DIV0_RESULT = 8'hFF;

  function automatic logic is_div_by_zero(input logic [1:0] op, input logic b_is_zero);
    return (op == OP_DIV) && b_is_zero;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO with a registered RAM read; an entry written into an otherwise
// empty FIFO becomes poppable one cycle later, once the read register holds it.
module alu_cmd_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_pop_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_fresh;

  logic             w_do_push;
  logic             w_do_pop;
  logic [AW-1:0]    w_rd_addr;
  logic             w_empty_after_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  // A head entry written at the last edge is not yet in the read register.
  assign o_empty = (r_count == '0) || r_fresh;
  assign o_count = r_count;
  assign o_pop_data = r_rd_data;

  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign w_rd_addr = w_do_pop ? (r_rd_ptr + AW'(1)) : r_rd_ptr;
  assign w_empty_after_pop = (r_count == '0) ||
                             ((r_count == (AW+1)'(1)) && w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
    r_rd_data <= r_mem[w_rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_fresh  <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      r_fresh <= w_do_push && w_empty_after_pop;
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands, drives registered operands into the external ALU,
// captures its result one cycle later and returns it over valid/ready.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int RES_W  = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [1:0]        cmd_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [1:0]        alu_s,
  input  logic [RES_W-1:0]  alu_c,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  res_data,
  output logic [1:0]        res_op,
  output logic              res_err,
  output logic              busy
);

  localparam int CMD_W = 2*DATA_W + 2;

  state_t              r_state;
  logic [DATA_W-1:0]   r_alu_a;
  logic [DATA_W-1:0]   r_alu_b;
  logic [1:0]          r_alu_s;
  logic                r_res_valid;
  logic [RES_W-1:0]    r_res_data;
  logic [1:0]          r_res_op;
  logic                r_res_err;

  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [$clog2(DEPTH):0] w_count;
  logic [CMD_W-1:0]    w_head;
  logic [DATA_W-1:0]   w_head_a;
  logic [DATA_W-1:0]   w_head_b;
  logic [1:0]          w_head_op;

  assign cmd_ready = !w_full;
  assign w_push    = cmd_valid && cmd_ready;
  assign w_pop     = !w_empty &&
                     ((r_state == ST_IDLE) || ((r_state == ST_RESP) && res_ready));

  assign w_head_op = w_head[CMD_W-1 -: 2];
  assign w_head_a  = w_head[2*DATA_W-1 -: DATA_W];
  assign w_head_b  = w_head[DATA_W-1:0];

  alu_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data ({cmd_op, cmd_a, cmd_b}),
    .i_pop       (w_pop),
    .o_pop_data  (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_s     <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_op    <= '0;
      r_res_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_alu_a <= w_head_a;
            r_alu_b <= w_head_b;
            r_alu_s <= w_head_op;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_res_op    <= r_alu_s;
          r_res_valid <= 1'b1;
          r_state     <= ST_RESP;
          // The ALU has no divide-by-zero detection, so its output is ignored here.
          if (is_div_by_zero(r_alu_s, r_alu_b == '0)) begin
            r_res_data <= RES_W'(DIV0_RESULT);
            r_res_err  <= 1'b1;
          end else begin
            r_res_data <= alu_c;
            r_res_err  <= 1'b0;
          end
        end
        ST_RESP: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            if (w_pop) begin
              r_alu_a <= w_head_a;
              r_alu_b <= w_head_b;
              r_alu_s <= w_head_op;
              r_state <= ST_EXEC;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_s     = r_alu_s;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_op    = r_res_op;
  assign res_err   = r_res_err;
  assign busy      = (w_count != '0) || (r_state != ST_IDLE);

endmodule
